conv_stream_checker: RTL and testbench

//  Self-checking scoreboard for the streaming 1-D convolution datapath.
//  - Snoops the input handshake and keeps a LEN-tap sliding window.
//  - Computes the golden dot product with the kernel and queues expected results.
//  - Compares each DUT output handshake against the queue head.
//  - Reports per-event errors, sticky flags, counters and a latency watchdog.
//  - Passive: drives no handshake signals; sits beside the conv DUT in the bench top.

---
 rtl/conv_stream_checker.sv | 175 +++++++++++++++++
 tb/tb_conv_stream_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_checker.sv
// conv_stream_checker
// Passive scoreboard for the streaming 1-D convolution datapath. It snoops the
// input handshake, keeps a LEN-tap sliding window plus a kernel snapshot, computes
// the golden dot product one cycle after each accepted sample, queues it, and
// compares every output handshake against the oldest queued expectation.
// Errors are reported as a registered one-cycle pulse, sticky flags and
// saturating counters. A watchdog flags results that never arrive.
module conv_stream_checker #(
  parameter int WIDTH   = 8,
  parameter int LEN     = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int SIGNED  = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic [LEN*WIDTH-1:0]              kernel,
  input  logic                              in_valid,
  input  logic                              in_ready,
  input  logic [2*WIDTH+$clog2(LEN)-1:0]    result,
  input  logic                              out_valid,
  input  logic                              out_ready,
  input  logic                              clear,
  output logic                              error,
  output logic                              error_sticky,
  output logic                              overflow,
  output logic                              underflow,
  output logic                              timeout,
  output logic [15:0]                       match_count,
  output logic [15:0]                       mismatch_count,
  output logic [$clog2(DEPTH+1)-1:0]        pending
);

  localparam int RES_W = 2*WIDTH + $clog2(LEN);
  localparam int PW    = $clog2(DEPTH+1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WDW   = $clog2(TIMEOUT+1);

  // Window and kernel snapshot packed as vectors; element i at [i*WIDTH +: WIDTH],
  // element 0 of the window is the oldest sample.
  logic [LEN*WIDTH-1:0] win_q;
  logic [LEN*WIDTH-1:0] kern_q;
  logic                 push_req;

  logic [RES_W-1:0]     exp_val;

  logic [RES_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [WDW-1:0]       wd_cnt;

  logic                 in_fire;
  logic                 out_fire;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 bypass;
  logic                 pop;
  logic                 store;
  logic                 drop;
  logic                 cmp_valid;
  logic [RES_W-1:0]     cmp_ref;
  logic                 mism_ev;
  logic                 match_ev;
  logic                 uflow_ev;
  logic                 wd_run;
  logic                 expire_ev;

  function automatic logic [RES_W-1:0] ext(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) return {{(RES_W-WIDTH){v[WIDTH-1]}}, v};
    else             return {{(RES_W-WIDTH){1'b0}}, v};
  endfunction

  // Golden dot product of the current window and kernel snapshot, truncated to RES_W.
  always_comb begin
    exp_val = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      exp_val = exp_val + ext(win_q[i*WIDTH +: WIDTH]) * ext(kern_q[i*WIDTH +: WIDTH]);
    end
  end

  // Handshake decode, FIFO steering and event classification.
  always_comb begin
    in_fire    = in_valid & in_ready;
    out_fire   = out_valid & out_ready;
    fifo_empty = (pending == '0);
    fifo_full  = (pending == PW'(DEPTH));
    // An output arriving while empty but with an expectation being produced
    // this cycle is checked directly against that expectation, never stored.
    bypass     = out_fire & fifo_empty & push_req;
    pop        = out_fire & ~fifo_empty;
    store      = push_req & ~bypass & (~fifo_full | pop);
    drop       = push_req & fifo_full & ~pop;
    cmp_valid  = out_fire & (~fifo_empty | push_req);
    cmp_ref    = fifo_empty ? exp_val : mem[rd_ptr];
    mism_ev    = cmp_valid & (result != cmp_ref);
    match_ev   = cmp_valid & (result == cmp_ref);
    uflow_ev   = out_fire & fifo_empty & ~push_req;
    wd_run     = ~fifo_empty & ~out_fire;
    expire_ev  = wd_run & (wd_cnt == WDW'(TIMEOUT-1));
  end

  // Input snoop: shift the window, snapshot the kernel, request a push next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      kern_q   <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= in_fire;
      if (in_fire) begin
        win_q  <= {in_data, win_q[LEN*WIDTH-1:WIDTH]};
        kern_q <= kernel;
      end
    end
  end

  // Expected-result storage; contents are only meaningful below pending.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= exp_val;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pending <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({store, pop})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Watchdog: counts stalled cycles while expectations are queued, saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (!wd_run) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WDW'(TIMEOUT)) begin
      wd_cnt <= wd_cnt + WDW'(1);
    end
  end

  // Reporting: error pulse, sticky flags and saturating counters; clear drops
  // any event of its own cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      error          <= 1'b0;
      error_sticky   <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      timeout        <= 1'b0;
      match_count    <= '0;
      mismatch_count <= '0;
    end else begin
      error <= mism_ev | uflow_ev | expire_ev;
      if (mism_ev | uflow_ev | expire_ev | drop) error_sticky <= 1'b1;
      if (drop)      overflow  <= 1'b1;
      if (uflow_ev)  underflow <= 1'b1;
      if (expire_ev) timeout   <= 1'b1;
      if (match_ev && match_count != '1)
        match_count <= match_count + 16'd1;
      if ((mism_ev || uflow_ev) && mismatch_count != '1)
        mismatch_count <= mismatch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_stream_checker.sv
// Directed bench for conv_stream_checker: golden stream, corrupted result,
// signed/unsigned extension, overflow and watchdog, underflow, clear, and
// continuous streams at latency 1 and 2 with mid-stream clear and reset.
module tb_conv_stream_checker;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int D  = 16;
  localparam int T  = 64;
  localparam int RW = 2*W + $clog2(L);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [L*W-1:0] kernel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready = 1'b0;
  logic [RW-1:0] result = '0;
  logic [RW-1:0] result_s = '0;
  logic          out_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear = 1'b0;

  logic          error, error_sticky, overflow, underflow, timeout;
  logic [15:0]   match_count, mismatch_count;
  logic [4:0]    pending;

  logic          s_error, s_error_sticky, s_overflow, s_underflow, s_timeout;
  logic [15:0]   s_match_count, s_mismatch_count;
  logic [4:0]    s_pending;

  int total = 0;
  int bad   = 0;

  int mw [4];
  int mk [4];
  int smp [8] = '{10, 200, 255, 7, 0, 99, 128, 31};
  int g [8];

  always #5 clk = ~clk;

  conv_stream_checker #(.WIDTH(W), .LEN(L), .DEPTH(D), .TIMEOUT(T), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .kernel(kernel),
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .clear(clear),
    .error(error), .error_sticky(error_sticky), .overflow(overflow),
    .underflow(underflow), .timeout(timeout), .match_count(match_count),
    .mismatch_count(mismatch_count), .pending(pending)
  );

  conv_stream_checker #(.WIDTH(W), .LEN(L), .DEPTH(D), .TIMEOUT(T), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_data(in_data), .kernel(kernel),
    .in_valid(in_valid), .in_ready(in_ready), .result(result_s),
    .out_valid(out_valid), .out_ready(out_ready), .clear(clear),
    .error(s_error), .error_sticky(s_error_sticky), .overflow(s_overflow),
    .underflow(s_underflow), .timeout(s_timeout), .match_count(s_match_count),
    .mismatch_count(s_mismatch_count), .pending(s_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_kernel(input int k0, input int k1, input int k2, input int k3);
    kernel = {k3[7:0], k2[7:0], k1[7:0], k0[7:0]};
    mk[0] = k0; mk[1] = k1; mk[2] = k2; mk[3] = k3;
  endtask

  // Unsigned reference: shift a sample into the model window, return the dot product.
  function automatic int model_shift(input int d);
    int s;
    mw[0] = mw[1]; mw[1] = mw[2]; mw[2] = mw[3]; mw[3] = d;
    s = 0;
    for (int i = 0; i < 4; i++) s += mw[i] * mk[i];
    return s % (1 << RW);
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mw[i] = 0;
  endtask

  task automatic send(input int d);
    int unused_exp;
    in_data = d[7:0]; in_valid = 1'b1; in_ready = 1'b1;
    unused_exp = model_shift(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input int r);
    result = r[RW-1:0]; out_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic run_stream(input int lat, input int clr_at);
    for (int n = 0; n < 8 + lat; n++) begin
      in_ready = 1'b1;
      in_valid = (n < 8);
      if (n < 8) begin
        in_data = smp[n][7:0];
        g[n] = model_shift(smp[n]);
      end
      out_valid = (n >= lat);
      out_ready = (n >= lat);
      if (n >= lat) result = g[n-lat][RW-1:0];
      clear = (n == clr_at);
      tick();
      clear = 1'b0;
      if (lat == 1) chk("bypass_pending", pending, 0);
      if (lat == 2) chk("lat2_pending", pending, (n >= 1 && n <= 8) ? 1 : 0);
      if (n == clr_at) chk("clear_match", match_count, 0);
      chk("stream_error", error, 0);
    end
    in_valid = 1'b0; out_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mw[i] = 0; mk[i] = 0; end

    // Reset state
    do_reset();
    chk("rst_error", error, 0);
    chk("rst_sticky", error_sticky, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_match", match_count, 0);
    chk("rst_mismatch", mismatch_count, 0);
    chk("rst_pending", pending, 0);

    // 1: golden stream, kernel 1,2,3,4 -> 4, 11, 20, 30
    set_kernel(1, 2, 3, 4);
    send(1); send(2); send(3); send(4);
    tick();
    chk("t1_pending4", pending, 4);
    recv(4); recv(11); recv(20); recv(30);
    chk("t1_match", match_count, 4);
    chk("t1_mismatch", mismatch_count, 0);
    chk("t1_sticky", error_sticky, 0);
    chk("t1_pending0", pending, 0);

    // 2: third result corrupted to 21
    do_reset();
    send(1); send(2); send(3); send(4);
    tick();
    recv(4);
    recv(11);
    chk("t2_err_before", error, 0);
    recv(21);
    chk("t2_err_pulse", error, 1);
    recv(30);
    chk("t2_err_after", error, 0);
    chk("t2_match", match_count, 3);
    chk("t2_mismatch", mismatch_count, 1);
    chk("t2_sticky", error_sticky, 1);

    // 3: kernel all FF, inputs 80: unsigned 32640*k, signed 128*k
    do_reset();
    set_kernel(255, 255, 255, 255);
    send(128); send(128); send(128); send(128);
    tick();
    for (int k = 1; k <= 4; k++) begin
      result_s = RW'(128 * k);
      recv(32640 * k);
    end
    chk("t3_u_match", match_count, 4);
    chk("t3_u_mismatch", mismatch_count, 0);
    chk("t3_s_match", s_match_count, 4);
    chk("t3_s_mismatch", s_mismatch_count, 0);

    // 4: 17 inputs with no outputs -> overflow, then watchdog 64 cycles after first push
    do_reset();
    set_kernel(1, 2, 3, 4);
    for (int i = 0; i < 17; i++) send(i + 1);
    tick();
    chk("t4_pending", pending, 16);
    chk("t4_overflow", overflow, 1);
    chk("t4_sticky", error_sticky, 1);
    chk("t4_no_err", error, 0);
    repeat (47) tick();
    chk("t4_timeout_early", timeout, 0);
    chk("t4_err_early", error, 0);
    tick();
    chk("t4_timeout", timeout, 1);
    chk("t4_err_pulse", error, 1);
    tick();
    chk("t4_err_once", error, 0);
    chk("t4_timeout_held", timeout, 1);

    // 5: underflow
    do_reset();
    recv(0);
    chk("t5_underflow", underflow, 1);
    chk("t5_mismatch", mismatch_count, 1);
    chk("t5_err_pulse", error, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_underflow", underflow, 0);
    chk("t5_clr_mismatch", mismatch_count, 0);
    chk("t5_clr_sticky", error_sticky, 0);

    // 6: continuous streams at latency 1 (bypass) and 2 with mid-stream clear
    do_reset();
    set_kernel(1, 2, 3, 4);
    run_stream(1, -1);
    chk("t6_l1_match", match_count, 8);
    chk("t6_l1_sticky", error_sticky, 0);
    run_stream(2, 4);
    chk("t6_l2_match", match_count, 5);
    chk("t6_l2_mismatch", mismatch_count, 0);
    chk("t6_l2_sticky", error_sticky, 0);

    // Reset mid-stream: expectations discarded, window zeroed
    send(9); send(17);
    tick();
    chk("t6_pre_rst_pending", pending, 2);
    do_reset();
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_match", match_count, 0);
    send(50);
    tick();
    chk("t6_post_pending", pending, 1);
    recv(200);
    chk("t6_post_match", match_count, 1);
    chk("t6_post_mismatch", mismatch_count, 0);
    chk("t6_post_err", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
